// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// The parity helper serves the IMEM_PARITY_EN build of imem_sync_fetch.
package imem_pkg;

  localparam logic [15:0] HALT_OPCODE = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } imem_state_e;

  // Source of the instruction output: the RAM read register or a forced constant.
  typedef enum logic {
    SRC_CONST = 1'b0,
    SRC_RAM   = 1'b1
  } out_src_e;

  // Even-parity bit; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x WIDTH instruction storage: synchronous write, synchronous read with enable.
// The read register holds its value while re is low.
module imem_ram #(
  parameter int    DEPTH     = 64,
  parameter int    WIDTH     = 16,
  parameter int    AW        = 6,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Array write and registered read; the array is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/imem_sync_fetch.sv
// Loadable synchronous-read instruction memory between PC and IF/ID, with stall/flush/halt.
// Define IMEM_PARITY_EN to store an even-parity bit per word and check it on read.
module imem_sync_fetch
  import imem_pkg::*;
#(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 16,
  parameter int    DEPTH     = 64,
  parameter int    BOOT_RUN  = 0,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] from_pc,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              halted,
  output logic              addr_err,
  output logic              parity_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-2:0] DEPTH_IDX   = (ADDR_W-1)'(DEPTH);
  localparam logic [DATA_W-1:0] HALT_W      = DATA_W'(HALT_OPCODE);
  localparam imem_state_e       RESET_STATE = (BOOT_RUN != 0) ? ST_RUN : ST_IDLE;

  imem_state_e       state_r, state_nx_s;
  out_src_e          src_r;
  logic [DATA_W-1:0] const_r;
  logic              instr_valid_r, addr_err_r, halted_r;
  logic [ADDR_W-2:0] fetch_idx_s, load_idx_s;
  logic              fetch_bad_s, fetch_go_s, halt_now_s;
  logic              ram_we_s, ram_re_s;
  logic [MEM_W-1:0]  ram_wdata_s, ram_rdata_s;
  logic [DATA_W-1:0] ram_data_s;
  logic              par_bad_s;

  assign fetch_idx_s = from_pc[ADDR_W-1:1];
  assign load_idx_s  = load_addr[ADDR_W-1:1];
  assign fetch_bad_s = from_pc[0] | (fetch_idx_s >= DEPTH_IDX);
  assign ram_we_s    = (state_r == ST_LOAD) & load_we & (load_idx_s < DEPTH_IDX);
  // A visible HALT that survives flush retires the block; no further fetches issue.
  assign halt_now_s  = (state_r == ST_RUN) & instr_valid_r & (instruction == HALT_W) & ~flush;
  assign fetch_go_s  = (state_r == ST_RUN) & ~load_en & ~halt_now_s & fetch_req & ~stall & ~flush;
  assign ram_re_s    = fetch_go_s & ~fetch_bad_s;

`ifdef IMEM_PARITY_EN
  logic fresh_r;

  assign ram_wdata_s = {even_parity(64'(load_data)), load_data};
  assign ram_data_s  = ram_rdata_s[DATA_W-1:0];
  assign par_bad_s   = (ram_rdata_s[DATA_W] != even_parity(64'(ram_data_s)));
  assign parity_err  = fresh_r & par_bad_s & (src_r == SRC_RAM);

  // Marks the single cycle in which a new RAM word is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fresh_r <= 1'b0;
    end else begin
      fresh_r <= ram_re_s;
    end
  end
`else
  assign ram_wdata_s = load_data;
  assign ram_data_s  = ram_rdata_s;
  assign par_bad_s   = 1'b0;
  assign parity_err  = 1'b0;
`endif

  imem_ram #(
    .DEPTH    (DEPTH),
    .WIDTH    (MEM_W),
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .waddr(load_idx_s[AW-1:0]),
    .wdata(ram_wdata_s),
    .re   (ram_re_s),
    .raddr(fetch_idx_s[AW-1:0]),
    .rdata(ram_rdata_s)
  );

  // Output mux: the RAM read register doubles as the instruction register.
  always_comb begin
    instruction = const_r;
    if (src_r == SRC_RAM) begin
      if (par_bad_s) begin
        instruction = HALT_W;
      end else begin
        instruction = ram_data_s;
      end
    end else begin
      instruction = const_r;
    end
  end

  // Next-state logic; load_en takes priority over start.
  always_comb begin
    state_nx_s = state_r;
    if (load_en) begin
      state_nx_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE:   state_nx_s = start ? ST_RUN : ST_IDLE;
        ST_LOAD:   state_nx_s = start ? ST_RUN : ST_LOAD;
        ST_RUN:    state_nx_s = halt_now_s ? ST_HALTED : ST_RUN;
        ST_HALTED: state_nx_s = ST_HALTED;
        default:   state_nx_s = RESET_STATE;
      endcase
    end
  end

  // State and output registers: flush over stall, HALTED freezes the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RESET_STATE;
      src_r         <= SRC_CONST;
      const_r       <= {DATA_W{1'b0}};
      instr_valid_r <= 1'b0;
      addr_err_r    <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      halted_r   <= (state_nx_s == ST_HALTED);
      addr_err_r <= 1'b0;
      if (state_nx_s == ST_LOAD) begin
        instr_valid_r <= 1'b0;
      end else if (state_r == ST_HALTED) begin
        instr_valid_r <= instr_valid_r;
      end else if (flush) begin
        instr_valid_r <= 1'b0;
        src_r         <= SRC_CONST;
        const_r       <= {DATA_W{1'b0}};
      end else if (fetch_go_s) begin
        instr_valid_r <= 1'b1;
        addr_err_r    <= fetch_bad_s;
        if (fetch_bad_s) begin
          src_r   <= SRC_CONST;
          const_r <= HALT_W;
        end else begin
          src_r   <= SRC_RAM;
        end
      end else if (!stall && !halt_now_s) begin
        instr_valid_r <= 1'b0;
      end else begin
        instr_valid_r <= instr_valid_r;
      end
    end
  end

  assign instr_valid = instr_valid_r;
  assign addr_err    = addr_err_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_imem_sync_fetch.sv
// Scoreboard bench for imem_sync_fetch: stimulus pushes expected outputs, a monitor pops them.
module tb_imem_sync_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0, load_we = 1'b0, start = 1'b0;
  logic [15:0] load_addr = 16'h0000, load_data = 16'h0000, from_pc = 16'h0000;
  logic        fetch_req = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [15:0] instruction;
  logic        instr_valid, halted, addr_err, parity_err;

  int compared = 0;
  int mismatched = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  imem_sync_fetch #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(64), .BOOT_RUN(0), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .start(start),
    .from_pc(from_pc), .fetch_req(fetch_req), .stall(stall), .flush(flush),
    .instruction(instruction), .instr_valid(instr_valid), .halted(halted),
    .addr_err(addr_err), .parity_err(parity_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid, non-halted output cycle consumes one expected entry.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && instr_valid && !halted) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: got instruction %h with no expected entry", instruction);
      end else begin
        e = exp_q.pop_front();
        check("mon_instruction", 32'(instruction), 32'(e[15:0]));
        check("mon_addr_err", 32'(addr_err), 32'(e[16]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_load();
    load_en = 1'b1;
    cyc();
    load_en = 1'b0;
  endtask

  task automatic go_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] addr, input logic [15:0] data);
    load_we = 1'b1;
    load_addr = addr;
    load_data = data;
    cyc();
    load_we = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] pc, input logic [15:0] exp_instr, input logic exp_err);
    from_pc = pc;
    fetch_req = 1'b1;
    exp_q.push_back({exp_err, exp_instr});
    cyc();
    fetch_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] stall_pcs [3];
    stall_pcs[0] = 16'h0002;
    stall_pcs[1] = 16'h0003;
    stall_pcs[2] = 16'h0080;

    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    check("reset_instruction", 32'(instruction), 32'h0);
    check("reset_valid", 32'(instr_valid), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    check("reset_addr_err", 32'(addr_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);

    // Program image and first fetches
    enter_load();
    load_word(16'h0000, 16'hFE21);
    load_word(16'h0002, 16'hFB22);
    load_word(16'h0004, 16'h2388);
    load_word(16'h003E, 16'h0000);
    check("load_valid_low", 32'(instr_valid), 32'h0);
    go_run();
    fetch(16'h0000, 16'hFE21, 1'b0);
    fetch(16'h0002, 16'hFB22, 1'b0);
    cyc();
    check("idle_valid_low", 32'(instr_valid), 32'h0);
    check("idle_instr_held", 32'(instruction), 32'h0000FB22);

    // Stall holds the output while from_pc wanders
    fetch(16'h0000, 16'hFE21, 1'b0);
    stall = 1'b1;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      from_pc = stall_pcs[i];
      exp_q.push_back({1'b0, 16'hFE21});
      cyc();
    end
    stall = 1'b0;
    fetch_req = 1'b0;
    cyc();
    check("post_stall_valid", 32'(instr_valid), 32'h0);

    // Flush beats stall and discards the concurrent fetch
    from_pc = 16'h0004;
    fetch_req = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    stall = 1'b0;
    fetch_req = 1'b0;
    check("flush_valid", 32'(instr_valid), 32'h0);
    check("flush_instruction", 32'(instruction), 32'h0);
    fetch(16'h0004, 16'h2388, 1'b0);
    cyc();

    // Misaligned and out-of-range fetches return HALT with addr_err, then halt
    fetch(16'h0003, 16'h0000, 1'b1);
    cyc();
    check("misaligned_addr_err_pulse", 32'(addr_err), 32'h0);
    check("misaligned_halted", 32'(halted), 32'h1);
    enter_load();
    go_run();
    fetch(16'h0080, 16'h0000, 1'b1);
    cyc();
    check("range_addr_err_pulse", 32'(addr_err), 32'h0);
    check("range_halted", 32'(halted), 32'h1);
    enter_load();
    go_run();

    // Stored HALT word halts; later fetches are ignored until load_en
    fetch(16'h003E, 16'h0000, 1'b0);
    cyc();
    check("halt_word_halted", 32'(halted), 32'h1);
    from_pc = 16'h0000;
    fetch_req = 1'b1;
    repeat (2) cyc();
    fetch_req = 1'b0;
    check("halted_frozen_instr", 32'(instruction), 32'h0);
    check("halted_frozen_valid", 32'(instr_valid), 32'h1);
    check("halted_still", 32'(halted), 32'h1);
    enter_load();
    check("exit_halt_halted", 32'(halted), 32'h0);
    check("exit_halt_valid", 32'(instr_valid), 32'h0);

    // Reset mid-load keeps written words
    go_run();
    fetch(16'h0000, 16'hFE21, 1'b0);
    enter_load();
    load_word(16'h0010, 16'h1111);
    load_word(16'h0012, 16'h2222);
    #2;
    rst_n = 1'b0;
    #1;
    check("midload_reset_instr", 32'(instruction), 32'h0);
    check("midload_reset_valid", 32'(instr_valid), 32'h0);
    check("midload_reset_halted", 32'(halted), 32'h0);
    check("midload_reset_addr_err", 32'(addr_err), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    go_run();
    fetch(16'h0010, 16'h1111, 1'b0);
    fetch(16'h0012, 16'h2222, 1'b0);
    cyc();

`ifdef IMEM_PARITY_EN
    dut.u_ram.mem_r[8] = dut.u_ram.mem_r[8] ^ 17'h00001;
    fetch(16'h0010, 16'h0000, 1'b0);
    check("parity_err_pulse", 32'(parity_err), 32'h1);
    cyc();
    check("parity_err_cleared", 32'(parity_err), 32'h0);
    check("parity_halted", 32'(halted), 32'h1);
`endif

    repeat (2) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
